// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders and an OR) plus a
// registered carry. Computes (a + b + cin) one bit per clock, LSB first, with
// valid/ready handshakes on the operand and result sides.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Counter only has to index bits 0..WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic ha0_s;
  logic ha0_c;
  logic bit_s;
  logic ha1_c;
  logic carry_next;
  logic last_bit;

  // Full-adder slice built from two half adders; carry-out is the OR of both.
  half_adder u_ha0 (
    .x (a_sh_reg[0]),
    .y (b_sh_reg[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .x (ha0_s),
    .y (carry_reg),
    .s (bit_s),
    .c (ha1_c)
  );

  assign carry_next = ha0_c | ha1_c;
  assign last_bit   = (cnt_reg == LAST_BIT);

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = bit_s;
    end else begin : g_res_wn
      assign res_next = {bit_s, res_sh_reg[WIDTH-1:1]};
    end
  endgenerate

  // Next-state logic and handshake/status outputs decoded from the state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and datapath; reset wins over everything and drops any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          carry_reg  <= carry_next;
          res_sh_reg <= res_next;
          if (last_bit) begin
            // Publish the finished word; sum/cout stay put until the next completion.
            sum_reg  <= res_next;
            cout_reg <= carry_next;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8. Inputs change on the falling
// edge; outputs are sampled on the falling edge, half a period from the active edge.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp;
  int n_bad;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand set, wait for the result; lat = edges after the accepting edge.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        output int lat, output bit ir_bad, output bit tmo);
    int w;
    ir_bad = 1'b0;
    tmo    = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); @(negedge clk); w++;
    end
    if (!in_ready) tmo = 1'b1;
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: rdy=%b vld=%b busy=%b sum=%h", in_ready, out_valid, busy, sum);
  endtask

  task automatic test_basic();
    int lat; bit irb; bit tmo;
    run_op(8'h3C, 8'h0F, 1'b0, lat, irb, tmo);
    $display("op 3c+0f+0: sum=%h cout=%b lat=%0d", sum, cout, lat);
    n_cmp++;
    if (tmo || lat != W) begin
      n_bad++; $display("FAIL basic_latency: got %0d (timeout=%b), want %0d", lat, tmo, W);
    end
    n_cmp++;
    if ({cout, sum} !== {1'b0, 8'h4B}) begin
      n_bad++; $display("FAIL basic_sum: got cout=%b sum=%h, want 0 4b", cout, sum);
    end
    n_cmp++;
    if (irb || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_ready: in_ready high in RUN=%b, done rdy=%b busy=%b, want 0 0 1",
                        irb, in_ready, busy);
    end
    consume();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL basic_release: got rdy/vld/busy=%b, want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_carries();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W:0]   ve [4];
    int lat; bit irb; bit tmo;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; ve[0] = 9'h100;
    va[1] = 8'hA5; vb[1] = 8'h5A; vc[1] = 1'b1; ve[1] = 9'h100;
    va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b0; ve[2] = 9'h000;
    va[3] = 8'h80; vb[3] = 8'h80; vc[3] = 1'b1; ve[3] = 9'h101;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], lat, irb, tmo);
      $display("op %h+%h+%b: sum=%h cout=%b lat=%0d", va[i], vb[i], vc[i], sum, cout, lat);
      n_cmp++;
      if (tmo || {cout, sum} !== ve[i]) begin
        n_bad++;
        $display("FAIL carry_%0d: got %h (timeout=%b), want %h", i, {cout, sum}, tmo, ve[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit irb; bit tmo;
    run_op(8'h11, 8'h22, 1'b0, lat, irb, tmo);
    a = 8'h40; b = 8'h07; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (tmo || {out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b0, 8'h33}) begin
        n_bad++;
        $display("FAIL hold_%0d: got vld=%b rdy=%b cout=%b sum=%h, want 1 0 0 33",
                 i, out_valid, in_ready, cout, sum);
      end
    end
    $display("backpressure: held sum=%h cout=%b for 5 cycles", sum, cout);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL bp_release: got rdy/vld/busy=%b, want 100", {in_ready, out_valid, busy});
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, busy} !== 2'b01) begin
      n_bad++; $display("FAIL bp_accept: got rdy/busy=%b, want 01", {in_ready, busy});
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    $display("op 40+07+1 after backpressure: sum=%h cout=%b", sum, cout);
    n_cmp++;
    if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h48}) begin
      n_bad++; $display("FAIL bp_result: got vld=%b cout=%b sum=%h, want 1 0 48", out_valid, cout, sum);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat; bit irb; bit tmo;
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    $display("reset mid-run: rdy=%b vld=%b busy=%b sum=%h cout=%b", in_ready, out_valid, busy, sum, cout);
    n_cmp++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    run_op(8'h12, 8'h34, 1'b0, lat, irb, tmo);
    $display("op 12+34+0 after reset: sum=%h cout=%b lat=%0d", sum, cout, lat);
    n_cmp++;
    if (tmo || lat != W || {cout, sum} !== {1'b0, 8'h46}) begin
      n_bad++; $display("FAIL post_reset: got lat=%0d cout=%b sum=%h, want %0d 0 46", lat, cout, sum, W);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W:0]   ve [4];
    int cyc; int acc_idx; int res_idx; int last_acc;
    bit will_accept;
    va[0] = 8'h01; vb[0] = 8'h02; vc[0] = 1'b0; ve[0] = 9'h003;
    va[1] = 8'h7F; vb[1] = 8'h01; vc[1] = 1'b0; ve[1] = 9'h080;
    va[2] = 8'hC8; vb[2] = 8'h64; vc[2] = 1'b1; ve[2] = 9'h12D;
    va[3] = 8'h55; vb[3] = 8'hAA; vc[3] = 1'b0; ve[3] = 9'h0FF;
    cyc = 0; acc_idx = 0; res_idx = 0; last_acc = -1;
    out_ready = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1;
    while (res_idx < 4 && cyc < 200) begin
      will_accept = 1'b0;
      if (out_valid) begin
        $display("b2b result %0d: sum=%h cout=%b at cycle %0d", res_idx, sum, cout, cyc);
        n_cmp++;
        if ({cout, sum} !== ve[res_idx]) begin
          n_bad++; $display("FAIL b2b_sum_%0d: got %h, want %h", res_idx, {cout, sum}, ve[res_idx]);
        end
        res_idx++;
      end
      if (in_ready && in_valid) begin
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != W + 2) begin
            n_bad++; $display("FAIL b2b_spacing_%0d: got %0d, want %0d", acc_idx, cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        will_accept = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
      if (will_accept) begin
        acc_idx++;
        if (acc_idx < 4) begin
          a = va[acc_idx]; b = vb[acc_idx]; cin = vc[acc_idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    n_cmp++;
    if (res_idx != 4) begin
      n_bad++; $display("FAIL b2b_timeout: got %0d results, want 4", res_idx);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carries();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial ripple adder. It adds two WIDTH-bit operands plus a carry-in, processing one bit per clock through a single full-adder slice (two half_adder instances plus an OR) and a registered carry. It is the sequential consumer of the half_adder cell, a low-area alternative to a parallel ripple adder. It uses valid/ready handshakes on both the operand and result sides.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands a, b, cin valid this cycle
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum/cout hold a completed result
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  registered sum (a+b+cin) mod 2^WIDTH
cout  output  1  registered carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, bit counter=0, carry register=0, shift registers=0.
- rst has priority over every other event, including mid-RUN and mid-DONE. Any in-flight operation is discarded with no partial result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid=1 at an edge, capture a and b into shift registers, load the carry register with cin, clear the counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge: s = a_sh[0]^b_sh[0]^c; c_next = majority(a_sh[0], b_sh[0], c).
  - Shift s into the MSB of the result shift register (right shift). Shift a_sh and b_sh right by 1. Increment the counter.
  - On the edge processing bit WIDTH-1: copy the result shift register (including that bit) to sum, copy c_next to cout, and go to DONE.
- DONE:
  - out_valid=1; sum and cout are stable.
  - If out_ready=1 at an edge, go to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle input acceptance.
- Latency: if operands are accepted at edge E0, out_valid is high in the cycle after edge E0+WIDTH.
- Throughput: minimum spacing between accepting edges is WIDTH+2 cycles when out_ready is held high.
- sum and cout change only on the RUN→DONE transition or on reset. They keep the last result through IDLE and the next RUN.
- WIDTH=1: RUN lasts exactly one edge.
- The counter is sized to hold 0..WIDTH-1.
- Backpressure: DONE is held indefinitely while out_ready=0.

Test Plan:
- WIDTH=8, a=0x3C, b=0x0F, cin=0, accepted at edge E0 → out_valid rises after E0+8; sum=0x4B, cout=0; in_ready low from E0+1 until return to IDLE.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1 (full carry ripple). Then a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1.
- a=0x00, b=0x00, cin=0 → sum=0x00, cout=0. Then a=0x80, b=0x80, cin=1 → sum=0x01, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → out_valid, sum and cout stay constant; the new operands are not accepted. Raise out_ready → IDLE next cycle, then the new operands are accepted.
- Reset mid-operation: assert rst at the 3rd RUN edge → next cycle state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0. A subsequent 0x12+0x34 yields sum=0x46.
- Back-to-back, out_ready tied 1, in_valid tied 1 with a sequence of operand pairs → accepting edges exactly 10 cycles apart; every result matches a+b+cin.
